clock_sequencer: RTL and testbench
==================================

# clock_sequencer

Master-clock sequencer for the NES core: divides the master clock into the CPU phase clocks and the CPU, PPU and APU clock enables, and schedules OAM DMA by stalling the CPU and driving the 256-byte copy to $2004. It sits between the board clock input and the CPU, PPU, APU and bus fabric. It is the single authority on which unit owns the CPU bus on each CPU cycle.

## Interface
Parameters:
- CPU_DIV, 12, master cycles per CPU cycle; even, at least 4
- PPU_DIV, 4, master cycles per PPU dot; at least 2

Ports:
- phi0  in  1  master clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- phi1  out  1  CPU phase 1 level
- phi2  out  1  CPU phase 2 level
- cpu_ce  out  1  one-master-cycle pulse ending each CPU cycle
- ppu_ce  out  1  one-master-cycle pulse per PPU dot
- apu_ce  out  1  cpu_ce on odd CPU cycles only
- dma_start  in  1  $4014 write strobe; sampled only when cpu_ce=1
- dma_page  in  8  source page, sampled with dma_start
- cpu_rdy  out  1  0 = CPU halted
- dma_active  out  1  DMA owns the bus
- dma_addr  out  16  DMA bus address
- dma_rd  out  1  DMA read cycle
- dma_wr  out  1  DMA write cycle
- dma_rdata  in  8  read data, sampled at the end of a read cycle
- dma_wdata  out  8  write data

## Operation
- cnt counts 0..CPU_DIV-1 and wraps. cpu_ce=1 when cnt==CPU_DIV-1.
- phi2=1 when cnt>=CPU_DIV/2. phi1=~phi2. phi1 and phi2 are registered and track cnt, with no combinational glitches.
- pcnt counts 0..PPU_DIV-1 and wraps. ppu_ce=1 when pcnt==PPU_DIV-1. pcnt is independent of cnt.
- Parity bit par toggles on each cpu_ce. apu_ce = cpu_ce & par.
- The DMA FSM advances only on master edges where cpu_ce=1. States and transitions:
  - IDLE: if dma_start=1, latch dma_page, clear idx and go to HALT.
  - HALT: cpu_rdy=0. Next state is ALIGN if par=1 on the following cycle, otherwise READ.
  - ALIGN: one dummy cycle, then READ.
  - READ: dma_rd=1, dma_addr={page, idx}. At exit, latch buf=dma_rdata and go to WRITE.
  - WRITE: dma_wr=1, dma_addr=16'h2004, dma_wdata=buf. At exit, idx increments. If idx was 255, go to IDLE; otherwise go to READ.
- READ always falls on par=0 cycles and WRITE on par=1 cycles.
- Total CPU stall is 513 cycles when dma_start is accepted with par=0, and 514 cycles when accepted with par=1.
- cpu_rdy=0 and dma_active=1 in every state except IDLE.
- dma_rd and dma_wr are never both 1. In IDLE, HALT and ALIGN both are 0 and dma_addr is 0.
- dma_start during a non-IDLE state is ignored; it is neither queued nor restarted.
- idx is 8 bits. Wrap-around from 255 to 0 coincides with the return to IDLE.

## Timing
- Reset values (immediate on reset_n=0, held until release):
  - cnt=0, pcnt=0, par=0
  - phi1=1, phi2=0
  - cpu_ce=0, ppu_ce=0, apu_ce=0
  - FSM=IDLE, idx=0, buf=0
  - cpu_rdy=1, dma_active=0, dma_addr=0, dma_rd=0, dma_wr=0, dma_wdata=0
- After reset release:
  - First cpu_ce is in master cycle CPU_DIV-1 (the 12th rising edge).
  - First ppu_ce is in master cycle PPU_DIV-1.
  - First apu_ce is with the second cpu_ce.
- State outputs (cpu_rdy, dma_*) are registered. They change on the rising edge that ends a cpu_ce cycle and hold for exactly CPU_DIV master cycles.
- Latency: if dma_start is accepted at the end of CPU cycle N, cpu_rdy=0 during cycle N+1. cpu_rdy returns to 1 at the start of cycle N+514 (par=0 start) or N+515 (par=1 start).
- Reset mid-DMA aborts with no further bus cycles. The next DMA needs a new dma_start.

## Test plan
- Reset and clocks: hold reset_n=0 for 7 edges and check all reset values. Release and run 24 master cycles.
  - cpu_ce must pulse at edges 12 and 24.
  - ppu_ce must pulse at edges 4, 8, ..., 24.
  - phi2 must be high for cnt 6..11.
  - apu_ce must pulse only at edge 24.
- Even DMA: pulse dma_start with dma_page=8'h02 on a par=0 cpu_ce.
  - cpu_rdy must stay low for exactly 513 CPU cycles.
  - First read address is 16'h0200; the last read, at 16'h02FF, is followed by the write at 16'h2004.
  - dma_wdata must equal the byte returned for the preceding read.
- Odd DMA: same as above but start on a par=1 cpu_ce. The stall must be 514 CPU cycles, including exactly one ALIGN cycle.
- Ignore start: re-pulse dma_start with dma_page=8'h07 at read index 100. Reads must continue from 16'h0265, and no 16'h07xx address may appear.
- Reset mid-DMA: assert reset_n=0 during the WRITE of index 40.
  - Outputs must return to reset values within the same master cycle.
  - After release, cpu_rdy=1 and no dma_rd or dma_wr appears without a new dma_start.
- Parameters: set CPU_DIV=4, PPU_DIV=2 and repeat the clock check. cpu_ce must pulse every 4 master cycles and ppu_ce every 2.

Source files
------------

// File: rtl/clock_sequencer.sv
// Master-clock sequencer: derives CPU phase clocks and CPU/PPU/APU clock enables,
// and runs OAM DMA (256 read/write pairs to $2004) while holding the CPU halted.
module clock_sequencer #(
    parameter int CPU_DIV = 12,
    parameter int PPU_DIV = 4
) (
    input  logic        phi0,
    input  logic        reset_n,
    output logic        phi1,
    output logic        phi2,
    output logic        cpu_ce,
    output logic        ppu_ce,
    output logic        apu_ce,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic        dma_wr,
    input  logic [7:0]  dma_rdata,
    output logic [7:0]  dma_wdata
);

    localparam int CW = $clog2(CPU_DIV);
    localparam int PW = $clog2(PPU_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t         state, state_nxt;
    logic           run;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [PW-1:0]  pcnt, pcnt_nxt;
    logic           par, par_nxt;
    logic           cpu_ce_nxt, ppu_ce_nxt, phi2_nxt;
    logic [7:0]     page, page_nxt;
    logic [7:0]     idx, idx_nxt;
    logic [7:0]     dbuf, dbuf_nxt;
    logic [15:0]    addr_nxt;
    logic [7:0]     wdata_nxt;

    // The first edge after reset release still belongs to master cycle 0, so the
    // counters only start advancing once run is set.
    always_comb begin
        cnt_nxt  = cnt;
        pcnt_nxt = pcnt;
        if (run) begin
            cnt_nxt  = (cnt == CW'(CPU_DIV - 1)) ? '0 : cnt + CW'(1);
            pcnt_nxt = (pcnt == PW'(PPU_DIV - 1)) ? '0 : pcnt + PW'(1);
        end
        cpu_ce_nxt = (cnt_nxt == CW'(CPU_DIV - 1));
        ppu_ce_nxt = (pcnt_nxt == PW'(PPU_DIV - 1));
        phi2_nxt   = (cnt_nxt >= CW'(CPU_DIV / 2));
        par_nxt    = par ^ cpu_ce;
    end

    always_ff @(posedge phi0 or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            cnt    <= '0;
            pcnt   <= '0;
            par    <= 1'b0;
            phi1   <= 1'b1;
            phi2   <= 1'b0;
            cpu_ce <= 1'b0;
            ppu_ce <= 1'b0;
            apu_ce <= 1'b0;
        end else begin
            run    <= 1'b1;
            cnt    <= cnt_nxt;
            pcnt   <= pcnt_nxt;
            par    <= par_nxt;
            phi1   <= ~phi2_nxt;
            phi2   <= phi2_nxt;
            cpu_ce <= cpu_ce_nxt;
            ppu_ce <= ppu_ce_nxt;
            apu_ce <= cpu_ce_nxt & par_nxt;
        end
    end

    // DMA sequencing: only moves at the edge that closes a CPU cycle.
    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        idx_nxt   = idx;
        dbuf_nxt  = dbuf;
        if (cpu_ce) begin
            case (state)
                S_IDLE: begin
                    if (dma_start) begin
                        page_nxt  = dma_page;
                        idx_nxt   = 8'd0;
                        state_nxt = S_HALT;
                    end
                end
                // The cycle after HALT has parity ~par; reads must land on even cycles.
                S_HALT:  state_nxt = par ? S_READ : S_ALIGN;
                S_ALIGN: state_nxt = S_READ;
                S_READ: begin
                    dbuf_nxt  = dma_rdata;
                    state_nxt = S_WRITE;
                end
                S_WRITE: begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_nxt  = 16'h0000;
        wdata_nxt = 8'h00;
        case (state_nxt)
            S_READ:  addr_nxt = {page_nxt, idx_nxt};
            S_WRITE: begin
                addr_nxt  = 16'h2004;
                wdata_nxt = dbuf_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge phi0 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            dbuf       <= 8'h00;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
            dma_addr   <= 16'h0000;
            dma_rd     <= 1'b0;
            dma_wr     <= 1'b0;
            dma_wdata  <= 8'h00;
        end else begin
            state      <= state_nxt;
            page       <= page_nxt;
            idx        <= idx_nxt;
            dbuf       <= dbuf_nxt;
            cpu_rdy    <= (state_nxt == S_IDLE);
            dma_active <= (state_nxt != S_IDLE);
            dma_addr   <= addr_nxt;
            dma_rd     <= (state_nxt == S_READ);
            dma_wr     <= (state_nxt == S_WRITE);
            dma_wdata  <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: clock-enable tables for two divider settings and
// DMA transfers checked cycle-by-cycle against a per-CPU-cycle bus model.
module tb_clock_sequencer;

    logic phi0 = 1'b0;
    always #5 phi0 = ~phi0;

    logic        reset_n, phi1, phi2, cpu_ce, ppu_ce, apu_ce, dma_start;
    logic        cpu_rdy, dma_active, dma_rd, dma_wr;
    logic [7:0]  dma_page, dma_rdata, dma_wdata;
    logic [15:0] dma_addr;

    logic        reset_nb, phi1_b, phi2_b, cpu_ce_b, ppu_ce_b, apu_ce_b, dma_start_b;
    logic        cpu_rdy_b, dma_active_b, dma_rd_b, dma_wr_b;
    logic [7:0]  dma_page_b, dma_rdata_b, dma_wdata_b;
    logic [15:0] dma_addr_b;

    logic [7:0]  memv [256];

    clock_sequencer #(.CPU_DIV(12), .PPU_DIV(4)) dut (
        .phi0(phi0), .reset_n(reset_n), .phi1(phi1), .phi2(phi2),
        .cpu_ce(cpu_ce), .ppu_ce(ppu_ce), .apu_ce(apu_ce),
        .dma_start(dma_start), .dma_page(dma_page), .cpu_rdy(cpu_rdy),
        .dma_active(dma_active), .dma_addr(dma_addr), .dma_rd(dma_rd),
        .dma_wr(dma_wr), .dma_rdata(dma_rdata), .dma_wdata(dma_wdata)
    );

    clock_sequencer #(.CPU_DIV(4), .PPU_DIV(2)) dut_b (
        .phi0(phi0), .reset_n(reset_nb), .phi1(phi1_b), .phi2(phi2_b),
        .cpu_ce(cpu_ce_b), .ppu_ce(ppu_ce_b), .apu_ce(apu_ce_b),
        .dma_start(dma_start_b), .dma_page(dma_page_b), .cpu_rdy(cpu_rdy_b),
        .dma_active(dma_active_b), .dma_addr(dma_addr_b), .dma_rd(dma_rd_b),
        .dma_wr(dma_wr_b), .dma_rdata(dma_rdata_b), .dma_wdata(dma_wdata_b)
    );

    // Memory model: byte depends on both page and offset so page errors show up.
    always_comb dma_rdata = memv[dma_addr[7:0]] ^ dma_addr[15:8];

    typedef struct {
        int   n;
        logic ce;
        logic pce;
        logic ace;
        logic p2;
    } clk_vec_t;

    clk_vec_t va [24];
    clk_vec_t vb [24];

    int tests = 0;
    int fails = 0;
    int ncyc  = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge phi0);
        #1;
    endtask

    // Advance to the next master cycle that carries cpu_ce; ncyc is the CPU cycle index.
    task automatic next_ce();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!cpu_ce && n < 40);
        ncyc++;
        if (!cpu_ce) begin
            tests++;
            fails++;
            $display("FAIL cpu_ce_timeout: got no cpu_ce within %0d master cycles", n);
        end
        chk("apu_parity", 64'(apu_ce), 64'(ncyc % 2));
    endtask

    function automatic clk_vec_t mk(int k, int cdiv, int pdiv);
        clk_vec_t v;
        int c, pc;
        c     = (k - 1) % cdiv;
        pc    = (k - 1) % pdiv;
        v.n   = k;
        v.ce  = (c == cdiv - 1);
        v.pce = (pc == pdiv - 1);
        v.p2  = (c >= cdiv / 2);
        v.ace = v.ce && (((k - 1) / cdiv) % 2 == 1);
        return v;
    endfunction

    // Expected {rdy, active, rd, wr, addr, wdata} for the k-th CPU cycle after
    // acceptance of a start made on a cycle of parity p.
    function automatic logic [27:0] exp_bus(int k, int p, logic [7:0] pg);
        int j;
        logic [7:0] ib;
        if (k == 1) return {4'b0100, 24'h0};
        j = k - 2 - p;
        if (j < 0) return {4'b0100, 24'h0};
        if (j >= 512) return {4'b1000, 24'h0};
        ib = 8'(j / 2);
        if (j % 2 == 0) return {4'b0110, pg, ib, 8'h00};
        return {4'b0101, 16'h2004, memv[ib] ^ pg};
    endfunction

    task automatic chk_reset(input string name);
        chk(name, 64'({phi1, phi2, cpu_ce, ppu_ce, apu_ce, cpu_rdy, dma_active,
                       dma_rd, dma_wr, dma_addr, dma_wdata}),
            64'({5'b10000, 4'b1000, 16'h0000, 8'h00}));
    endtask

    task automatic run_dma(input logic [7:0] pg, input int p, input int ign_k, input int rst_k);
        int stall, quiet, lim;
        bit was_reset;
        stall = 0;
        quiet = 0;
        was_reset = 0;
        while ((ncyc % 2) != p) next_ce();
        dma_page  = pg;
        dma_start = 1'b1;
        lim = 514 + p + 2;
        for (int k = 1; k <= lim; k++) begin
            next_ce();
            if (k == ign_k) begin
                dma_page  = 8'h07;
                dma_start = 1'b1;
            end else begin
                dma_start = 1'b0;
            end
            chk($sformatf("dma_bus_pg%02h_k%0d", pg, k),
                64'({cpu_rdy, dma_active, dma_rd, dma_wr, dma_addr, dma_wdata}),
                64'(exp_bus(k, p, pg)));
            if (!cpu_rdy) stall++;
            if (dma_active && !dma_rd && !dma_wr) quiet++;
            if (k == rst_k) begin
                #2 reset_n = 1'b0;
                #1 chk_reset("mid_dma_reset_async");
                dma_start = 1'b0;
                was_reset = 1;
                break;
            end
        end
        if (was_reset) begin
            repeat (3) step();
            chk_reset("mid_dma_reset_hold");
            reset_n = 1'b1;
            ncyc = -1;
            for (int c = 0; c < 40; c++) begin
                next_ce();
                chk("post_reset_idle",
                    64'({cpu_rdy, dma_active, dma_rd, dma_wr, dma_addr, dma_wdata}),
                    64'({4'b1000, 24'h0}));
            end
        end else begin
            chk($sformatf("stall_len_p%0d", p), 64'(stall), 64'(513 + p));
            chk($sformatf("halt_align_cycles_p%0d", p), 64'(quiet), 64'(1 + p));
        end
    endtask

    initial begin
        int r;
        reset_n     = 1'b0;
        reset_nb    = 1'b0;
        dma_start   = 1'b0;
        dma_page    = 8'h00;
        dma_start_b = 1'b0;
        dma_page_b  = 8'h00;
        dma_rdata_b = 8'h00;
        for (int i = 0; i < 256; i++) memv[i] = 8'($urandom);
        for (int k = 1; k <= 24; k++) begin
            va[k-1] = mk(k, 12, 4);
            vb[k-1] = mk(k, 4, 2);
        end

        repeat (7) step();
        chk_reset("reset_values");
        chk("reset_values_b",
            64'({phi1_b, phi2_b, cpu_ce_b, ppu_ce_b, apu_ce_b, cpu_rdy_b, dma_active_b,
                 dma_rd_b, dma_wr_b, dma_addr_b, dma_wdata_b}),
            64'({5'b10000, 4'b1000, 24'h0}));

        reset_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk($sformatf("clk12_edge%0d", va[i].n),
                64'({cpu_ce, ppu_ce, apu_ce, phi2, phi1, cpu_rdy}),
                64'({va[i].ce, va[i].pce, va[i].ace, va[i].p2, ~va[i].p2, 1'b1}));
        end
        ncyc = 1;

        run_dma(8'h02, 0, -1, -1);
        run_dma(8'h02, 1, 203, -1);
        for (int t = 0; t < 2; t++) run_dma(8'($urandom), int'($urandom_range(0, 1)), -1, -1);
        r = int'($urandom_range(0, 1));
        run_dma(8'($urandom), r, -1, 83 + r);

        reset_nb = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            chk($sformatf("clk4_edge%0d", vb[i].n),
                64'({cpu_ce_b, ppu_ce_b, apu_ce_b, phi2_b, phi1_b, cpu_rdy_b}),
                64'({vb[i].ce, vb[i].pce, vb[i].ace, vb[i].p2, ~vb[i].p2, 1'b1}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
